// File: rtl/spi_coef_tx.sv
// Serial coefficient transmitter: sends a header byte, 32 zero-padded 5-bit coefficients
// and an XOR checksum MSB first on MOSI while cs_n is low, then holds cs_n high for a short gap.
module spi_coef_tx #(
    parameter logic [7:0] HEADER     = 8'hA5,
    parameter int         GAP_CYCLES = 2
) (
    input  logic         SCLK,
    input  logic         reset,
    input  logic         start,
    input  logic [159:0] coef_flat,
    output logic         MOSI,
    output logic         cs_n,
    output logic         busy,
    output logic         done
);

    // state     | meaning
    // ST_IDLE   | waiting for start, link quiet
    // ST_HEADER | shifting the sync byte
    // ST_DATA   | shifting the 32 coefficient bytes
    // ST_CHECK  | shifting the XOR checksum byte
    // ST_GAP    | cs_n high between frames, done on the last cycle
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    logic [2:0]   state;
    logic [159:0] snap;
    logic [7:0]   byte_q;
    logic [7:0]   chk;
    logic [7:0]   chk_nxt;
    logic [7:0]   data_byte;
    logic [4:0]   byte_idx;
    logic [4:0]   word_idx;
    logic [2:0]   bit_idx;
    logic [3:0]   gap_cnt;
    logic         launch;

    assign busy = (state != ST_IDLE);

    // A held start re-launches straight out of the last gap cycle so frames
    // are separated by exactly GAP_CYCLES high cs_n cycles.
    assign launch = start && ((state == ST_IDLE) || (state == ST_GAP && gap_cnt == 4'd0));

    always_comb begin
        chk_nxt   = chk ^ byte_q;
        word_idx  = (state == ST_DATA) ? byte_idx + 5'd1 : 5'd0;
        data_byte = {3'b000, snap[5*word_idx +: 5]};
    end

    always_ff @(posedge SCLK) begin
        if (reset) begin
            state    <= ST_IDLE;
            snap     <= '0;
            byte_q   <= '0;
            chk      <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            MOSI     <= 1'b0;
            cs_n     <= 1'b1;
            done     <= 1'b0;
        end else if (launch) begin
            state    <= ST_HEADER;
            snap     <= coef_flat;
            byte_q   <= HEADER;
            chk      <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            MOSI     <= HEADER[7];
            cs_n     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    MOSI <= 1'b0;
                    cs_n <= 1'b1;
                end
                ST_HEADER, ST_DATA, ST_CHECK: begin
                    if (bit_idx != 3'd7) begin
                        bit_idx <= bit_idx + 3'd1;
                        MOSI    <= byte_q[3'd6 - bit_idx];
                    end else begin
                        chk     <= chk_nxt;
                        bit_idx <= '0;
                        if (state == ST_CHECK) begin
                            state   <= ST_GAP;
                            cs_n    <= 1'b1;
                            MOSI    <= 1'b0;
                            gap_cnt <= GAP_LAST;
                            done    <= (GAP_CYCLES == 1);
                        end else if (state == ST_DATA && byte_idx == 5'd31) begin
                            state  <= ST_CHECK;
                            byte_q <= chk_nxt;
                            MOSI   <= chk_nxt[7];
                        end else begin
                            state    <= ST_DATA;
                            byte_idx <= word_idx;
                            byte_q   <= data_byte;
                            MOSI     <= data_byte[7];
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                        done    <= (gap_cnt == 4'd1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_coef_tx.sv
// Self-checking bench for spi_coef_tx: frames are rebuilt from the coefficient words
// and compared byte by byte, along with cs_n window, gap and done timing.
module tb_spi_coef_tx;

    localparam int         GAP = 2;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int         NBIT = 272;

    logic         SCLK = 1'b0;
    logic         reset;
    logic         start;
    logic [159:0] coef_flat;
    logic         MOSI;
    logic         cs_n;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_b [34];
    logic [7:0] rx_b  [34];
    logic       rx_bits [NBIT];

    spi_coef_tx #(.HEADER(HDR), .GAP_CYCLES(GAP)) dut (
        .SCLK      (SCLK),
        .reset     (reset),
        .start     (start),
        .coef_flat (coef_flat),
        .MOSI      (MOSI),
        .cs_n      (cs_n),
        .busy      (busy),
        .done      (done)
    );

    always #5 SCLK = ~SCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, one zero-padded byte per word, XOR of everything before.
    function automatic void model_frame(input logic [159:0] c);
        exp_b[0] = HDR;
        for (int i = 0; i < 32; i++) exp_b[i+1] = {3'b000, c[5*i +: 5]};
        exp_b[33] = 8'h00;
        for (int i = 0; i < 33; i++) exp_b[33] = exp_b[33] ^ exp_b[i];
    endfunction

    function automatic logic [159:0] rand_coef();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Launches one frame with a start pulse and watches it through to the idle cycle.
    task automatic frame_test(input string tag, input logic [159:0] c, input int chg_at,
                              input logic [159:0] chg_val, input int start_at);
        int low_cnt, done_cnt, done_pos, busy_bad, gap_bad;
        model_frame(c);
        low_cnt = 0; done_cnt = 0; done_pos = -1; busy_bad = 0; gap_bad = 0;
        @(negedge SCLK);
        coef_flat = c;
        start = 1'b1;
        @(negedge SCLK);
        start = 1'b0;
        for (int k = 1; k <= NBIT + GAP + 1; k++) begin
            if (k <= NBIT) rx_b[(k-1)/8] = {rx_b[(k-1)/8][6:0], MOSI};
            if (!cs_n) low_cnt++;
            if (k > NBIT && k <= NBIT + GAP && (cs_n !== 1'b1 || MOSI !== 1'b0)) gap_bad++;
            if (done) begin done_cnt++; done_pos = k; end
            if (busy !== (k <= NBIT + GAP)) busy_bad++;
            if (k == chg_at) coef_flat = chg_val;
            start = (k == start_at);
            if (k < NBIT + GAP + 1) @(negedge SCLK);
        end
        start = 1'b0;
        for (int j = 0; j < 34; j++) check($sformatf("%s byte%0d", tag, j), 32'(rx_b[j]), 32'(exp_b[j]));
        check({tag, " cs_low"}, low_cnt, NBIT);
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " done_pos"}, done_pos, NBIT + GAP);
        check({tag, " busy"}, busy_bad, 0);
        check({tag, " gap"}, gap_bad, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " cs_n"}, 32'(cs_n), 1);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " MOSI"}, 32'(MOSI), 0);
        check({tag, " done"}, 32'(done), 0);
    endtask

    // Receiver model for back-to-back frames: decodes bits into words and checks framing.
    task automatic held_test(input logic [159:0] c);
        int bitcnt, frames, dones, gap_run, stray;
        logic in_frame;
        logic [7:0] x;
        logic [159:0] rec;
        bitcnt = 0; frames = 0; dones = 0; gap_run = 0; stray = 0; in_frame = 1'b0;
        @(negedge SCLK);
        coef_flat = c;
        start = 1'b1;
        for (int k = 0; k < 2000 && dones < 3; k++) begin
            @(negedge SCLK);
            if (!cs_n) begin
                if (!in_frame && frames > 0) check($sformatf("held gap%0d", frames), gap_run, GAP);
                in_frame = 1'b1;
                if (bitcnt < NBIT) rx_bits[bitcnt] = MOSI;
                bitcnt++;
            end else begin
                if (in_frame) begin
                    check($sformatf("held len%0d", frames), bitcnt, NBIT);
                    for (int j = 0; j < 34; j++)
                        for (int b = 0; b < 8; b++) rx_b[j][7-b] = rx_bits[8*j + b];
                    x = 8'h00;
                    for (int j = 0; j < 34; j++) x = x ^ rx_b[j];
                    for (int i = 0; i < 32; i++) rec[5*i +: 5] = rx_b[i+1][4:0];
                    check($sformatf("held hdr%0d", frames), 32'(rx_b[0]), 32'(HDR));
                    check($sformatf("held xor%0d", frames), 32'(x), 0);
                    check($sformatf("held coef%0d", frames), 32'(rec != c), 0);
                    frames++;
                    bitcnt = 0;
                    gap_run = 0;
                    in_frame = 1'b0;
                end
                gap_run++;
            end
            if (done) dones++;
            if (dones == 3) start = 1'b0;
        end
        check("held dones", dones, 3);
        repeat (GAP + 1) @(negedge SCLK);
        for (int k = 0; k < 20; k++) begin
            @(negedge SCLK);
            if (!cs_n || done) stray++;
        end
        check("held frames", frames + (in_frame ? 1 : 0), 3);
        check("held stray", stray, 0);
    endtask

    initial begin
        logic [159:0] c;
        int low_cnt, done_cnt;
        reset = 1'b1;
        start = 1'b1;
        coef_flat = '1;
        repeat (3) @(negedge SCLK);
        check_idle("rst");
        reset = 1'b0;
        start = 1'b0;
        @(negedge SCLK);
        check_idle("idle");

        frame_test("zero", '0, -1, '0, -1);
        frame_test("w0", 160'h1, -1, '0, -1);
        check("w0 data0", 32'(rx_b[1]), 32'h01);
        check("w0 chk", 32'(rx_b[33]), 32'hA4);
        frame_test("ones", '1, 50, '0, -1);
        check("ones chk", 32'(rx_b[33]), 32'hA5);
        frame_test("ign", rand_coef(), -1, '0, 100);
        for (int r = 0; r < 3; r++)
            frame_test($sformatf("rnd%0d", r), rand_coef(), $urandom_range(1, 270), rand_coef(), -1);

        // abort during DATA byte 10 (bits occupy cycles 89..96)
        @(negedge SCLK);
        coef_flat = rand_coef();
        start = 1'b1;
        @(negedge SCLK);
        start = 1'b0;
        repeat (91) @(negedge SCLK);
        reset = 1'b1;
        @(negedge SCLK);
        reset = 1'b0;
        check_idle("abort");
        low_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge SCLK);
            if (!cs_n) low_cnt++;
            if (done) done_cnt++;
        end
        check("abort low", low_cnt, 0);
        check("abort done", done_cnt, 0);
        frame_test("fresh", rand_coef(), -1, '0, -1);

        c = rand_coef();
        held_test(c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
